// File: rtl/mmv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmv_arbiter
// Purpose  : Round-robin arbiter sharing one MemoryMapped slave among NPORTS
//            MemoryMapped masters. Outstanding reads are tracked in an ordered
//            queue of port indices, so each returned read word is routed back
//            to the port that issued the read.
// Ports    : rst, clk          - asynchronous active-high reset, clock
//            s_addr/s_wdat     - per-port address / write data (packed, port i
//                                at [i*W +: W])
//            s_wreq/s_rreq     - per-port write / read request
//            s_rdat/s_rval     - shared read data, per-port read-data-valid
//            s_busy            - per-port stall
//            m_addr/m_wdat     - address / write data to the slave
//            m_wreq/m_rreq     - write / read request to the slave
//            m_rdat/m_rval     - read data / read-data-valid from the slave
//            m_busy            - stall from the slave
//            rval_is_odd       - pulse: m_rval seen with no read outstanding
// Revision : 1.0 - initial release
// ============================================================================
module mmv_arbiter #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 8,
  parameter int NPORTS    = 4,
  parameter int MAXPENDRD = 8
) (
  input  logic                       rst,
  input  logic                       clk,
  input  logic [NPORTS*AWIDTH-1:0]   s_addr,
  input  logic [NPORTS-1:0]          s_wreq,
  input  logic [NPORTS*DWIDTH-1:0]   s_wdat,
  input  logic [NPORTS-1:0]          s_rreq,
  output logic [DWIDTH-1:0]          s_rdat,
  output logic [NPORTS-1:0]          s_rval,
  output logic [NPORTS-1:0]          s_busy,
  output logic [AWIDTH-1:0]          m_addr,
  output logic                       m_wreq,
  output logic [DWIDTH-1:0]          m_wdat,
  output logic                       m_rreq,
  input  logic [DWIDTH-1:0]          m_rdat,
  input  logic                       m_rval,
  input  logic                       m_busy,
  output logic                       rval_is_odd
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;     // port index
  localparam int c_QW = (MAXPENDRD > 1) ? $clog2(MAXPENDRD) : 1; // queue ptr
  localparam int c_CW = $clog2(MAXPENDRD + 1);                  // queue count

  localparam logic [c_PW:0]   c_NPORTS_W = (c_PW + 1)'(NPORTS);
  localparam logic [c_PW-1:0] c_LAST_PORT = c_PW'(NPORTS - 1);
  localparam logic [c_QW-1:0] c_QLAST    = c_QW'(MAXPENDRD - 1);
  localparam logic [c_CW-1:0] c_QDEPTH   = c_CW'(MAXPENDRD);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] r_ptr;        // search start for the next unlocked grant
  logic            r_lock;       // grant frozen on r_lock_idx
  logic [c_PW-1:0] r_lock_idx;
  logic [c_PW-1:0] r_mem [MAXPENDRD];
  logic [c_QW-1:0] r_wptr;
  logic [c_QW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NPORTS-1:0] w_req;
  logic              w_scan_hit;
  logic [c_PW-1:0]   w_scan_idx;
  logic              w_gnt_valid;
  logic [c_PW-1:0]   w_gnt_idx;
  logic [NPORTS-1:0] w_grant;
  logic              w_sel_wreq;
  logic              w_sel_rreq;
  logic              w_sel_req;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [c_PW-1:0]   w_ptr_next;
  logic [c_PW-1:0]   w_head;
  logic [NPORTS-1:0] w_head_onehot;
  logic [AWIDTH-1:0] w_addr_arr [NPORTS];
  logic [DWIDTH-1:0] w_wdat_arr [NPORTS];

  assign w_req = s_wreq | s_rreq;

  // Unpack the per-port buses and build the per-port stall / one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      assign w_addr_arr[gi]    = s_addr[gi*AWIDTH +: AWIDTH];
      assign w_wdat_arr[gi]    = s_wdat[gi*DWIDTH +: DWIDTH];
      assign w_grant[gi]       = w_gnt_valid && (w_gnt_idx == c_PW'(gi));
      assign s_busy[gi]        = ~w_grant[gi] | m_busy | (s_rreq[gi] & w_full);
      assign w_head_onehot[gi] = (w_head == c_PW'(gi));
    end
  endgenerate

  // Round-robin search: first requesting port at or after r_ptr, wrapping
  // from NPORTS-1 back to 0. r_ptr is always < NPORTS, so a single
  // conditional subtraction is enough to wrap the sum.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      logic [c_PW:0] sum;
      sum = {1'b0, r_ptr} + (c_PW + 1)'(k);
      if (sum >= c_NPORTS_W) begin
        sum = sum - c_NPORTS_W;
      end
      if (!w_scan_hit && w_req[sum[c_PW-1:0]]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = sum[c_PW-1:0];
      end
    end
  end

  // A stalled grant stays on its port even if a port nearer r_ptr starts
  // requesting meanwhile, so the locked index is held in its own register.
  assign w_gnt_valid = r_lock | w_scan_hit;
  assign w_gnt_idx   = r_lock ? r_lock_idx : w_scan_idx;

  assign w_sel_wreq  = s_wreq[w_gnt_idx];
  assign w_sel_rreq  = s_rreq[w_gnt_idx];
  assign w_sel_req   = w_sel_wreq | w_sel_rreq;

  assign w_full      = (r_count == c_QDEPTH);
  assign w_empty     = (r_count == '0);

  // Accepted: granted port is requesting and not stalled by the slave or,
  // for a read, by a full queue.
  assign w_accept    = w_gnt_valid & w_sel_req & ~m_busy & ~(w_sel_rreq & w_full);
  assign w_push      = w_accept & w_sel_rreq;
  assign w_pop       = m_rval & ~w_empty;

  assign w_ptr_next  = (w_gnt_idx == c_LAST_PORT) ? '0 : w_gnt_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Forwarding to the slave
  // --------------------------------------------------------------------------
  assign m_addr = w_addr_arr[w_gnt_idx];
  assign m_wdat = w_wdat_arr[w_gnt_idx];
  assign m_wreq = w_gnt_valid & w_sel_wreq;
  assign m_rreq = w_gnt_valid & w_sel_rreq & ~w_full;

  assign w_head = r_mem[r_rptr];

  // --------------------------------------------------------------------------
  // Arbitration state, read queue control and return path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      s_rval      <= '0;
      s_rdat      <= '0;
      rval_is_odd <= 1'b0;
    end else begin
      // Lock whenever a request was presented on the grant but not taken.
      // A locked port that drops its request simply unlocks here.
      r_lock     <= w_gnt_valid & w_sel_req & ~w_accept;
      r_lock_idx <= w_gnt_idx;

      if (w_accept) begin
        r_ptr <= w_ptr_next;
      end

      if (w_push) begin
        r_wptr <= (r_wptr == c_QLAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_QLAST) ? '0 : r_rptr + 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (m_rval) begin
        s_rdat <= m_rdat;
      end
      s_rval      <= w_pop ? w_head_onehot : '0;
      // A response with nothing outstanding is flagged and dropped.
      rval_is_odd <= m_rval & w_empty;
    end
  end

  // Queue storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_gnt_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmv_arbiter
// Purpose  : Randomized self-checking bench for mmv_arbiter against a
//            transaction-level reference model (round-robin order, lock on
//            stall, ordered queue of outstanding read owners).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmv_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NP  = 4;
  localparam int MPR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*AW-1:0]  s_addr;
  logic [NP-1:0]     s_wreq;
  logic [NP*DW-1:0]  s_wdat;
  logic [NP-1:0]     s_rreq;
  logic [DW-1:0]     s_rdat;
  logic [NP-1:0]     s_rval;
  logic [NP-1:0]     s_busy;
  logic [AW-1:0]     m_addr;
  logic              m_wreq;
  logic [DW-1:0]     m_wdat;
  logic              m_rreq;
  logic [DW-1:0]     m_rdat;
  logic              m_rval;
  logic              m_busy;
  logic              rval_is_odd;

  mmv_arbiter #(
    .AWIDTH    (AW),
    .DWIDTH    (DW),
    .NPORTS    (NP),
    .MAXPENDRD (MPR)
  ) dut (
    .rst         (rst),
    .clk         (clk),
    .s_addr      (s_addr),
    .s_wreq      (s_wreq),
    .s_wdat      (s_wdat),
    .s_rreq      (s_rreq),
    .s_rdat      (s_rdat),
    .s_rval      (s_rval),
    .s_busy      (s_busy),
    .m_addr      (m_addr),
    .m_wreq      (m_wreq),
    .m_wdat      (m_wdat),
    .m_rreq      (m_rreq),
    .m_rdat      (m_rdat),
    .m_rval      (m_rval),
    .m_busy      (m_busy),
    .rval_is_odd (rval_is_odd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            mptr;
  bit            mlock;
  int            mlock_port;
  int            q[$];
  logic [NP-1:0] e_rval;
  logic [DW-1:0] e_rdat;
  bit            e_odd;

  // Requester state: a pending transaction is held until the model accepts it
  bit            pend [NP];
  bit            pw   [NP];
  bit            pr   [NP];
  logic [AW-1:0] pa   [NP];
  logic [DW-1:0] pd   [NP];

  task automatic model_reset();
    mptr   = 0;
    mlock  = 1'b0;
    mlock_port = 0;
    q.delete();
    e_rval = '0;
    e_rdat = '0;
    e_odd  = 1'b0;
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
  endtask

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      s_wreq[i]          = pend[i] && pw[i];
      s_rreq[i]          = pend[i] && pr[i];
      s_addr[i*AW +: AW] = pa[i];
      s_wdat[i*DW +: DW] = pd[i];
    end
  endtask

  task automatic new_stimulus();
    int kind;
    for (int i = 0; i < NP; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < 40) begin
        pend[i] = 1'b1;
        kind    = $urandom_range(0, 9);
        pw[i]   = (kind < 5) || (kind == 9);
        pr[i]   = (kind >= 5);
        pa[i]   = AW'($urandom);
        pd[i]   = DW'($urandom);
      end
    end
    m_busy = ($urandom_range(0, 99) < 25);
    m_rval = ($urandom_range(0, 99) < 30);
    m_rdat = DW'($urandom);
  endtask

  // One clock: check the combinational request path, advance the model over
  // the rising edge, then check the registered return path.
  task automatic run_cycle();
    int            g;
    int            p;
    int            h;
    bit            full;
    bit            acc;
    bit            req_g;
    logic [NP-1:0] busy_exp;
    #1;
    full = (q.size() == MPR);
    g    = -1;
    if (mlock) begin
      g = mlock_port;
    end else begin
      for (int k = 0; k < NP; k++) begin
        p = (mptr + k) % NP;
        if (g < 0 && (s_wreq[p] || s_rreq[p])) g = p;
      end
    end
    for (int i = 0; i < NP; i++) begin
      busy_exp[i] = (i != g) || m_busy || (s_rreq[i] && full);
    end
    req_g = (g >= 0) ? (s_wreq[g] || s_rreq[g]) : 1'b0;
    check_eq("s_busy", 32'(s_busy), 32'(busy_exp));
    check_eq("m_wreq", 32'(m_wreq), (g >= 0) ? 32'(s_wreq[g]) : 32'd0);
    check_eq("m_rreq", 32'(m_rreq), (g >= 0) ? 32'(s_rreq[g] && !full) : 32'd0);
    if (g >= 0) begin
      check_eq("m_addr", 32'(m_addr), 32'(pa[g]));
      check_eq("m_wdat", 32'(m_wdat), 32'(pd[g]));
    end
    acc = (g >= 0) && req_g && !busy_exp[g];

    @(posedge clk);
    #1;
    e_odd = m_rval && (q.size() == 0);
    if (m_rval && q.size() > 0) begin
      h      = q.pop_front();
      e_rval = NP'(1) << h;
    end else begin
      e_rval = '0;
    end
    if (m_rval) e_rdat = m_rdat;
    if (acc && s_rreq[g]) q.push_back(g);
    mlock      = (g >= 0) && req_g && !acc;
    mlock_port = g;
    if (acc) begin
      mptr    = (g + 1) % NP;
      pend[g] = 1'b0;
    end
    check_eq("s_rval", 32'(s_rval), 32'(e_rval));
    check_eq("s_rdat", 32'(s_rdat), 32'(e_rdat));
    check_eq("rval_is_odd", 32'(rval_is_odd), 32'(e_odd));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " s_rval"}, 32'(s_rval), 32'd0);
    check_eq({tag, " s_rdat"}, 32'(s_rdat), 32'd0);
    check_eq({tag, " rval_is_odd"}, 32'(rval_is_odd), 32'd0);
    check_eq({tag, " s_busy"}, 32'(s_busy), 32'(NP'('1)));
    check_eq({tag, " m_wreq"}, 32'(m_wreq), 32'd0);
    check_eq({tag, " m_rreq"}, 32'(m_rreq), 32'd0);
  endtask

  // Asynchronous reset mid-operation: pending read owners are discarded.
  task automatic do_reset();
    rst    = 1'b1;
    m_rval = 1'b0;
    m_busy = 1'b0;
    model_reset();
    drive_ports();
    #1;
    check_reset_state("mid reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    m_rval = 1'b0;
    m_busy = 1'b0;
    m_rdat = '0;
    for (int i = 0; i < NP; i++) begin
      pw[i] = 1'b0;
      pr[i] = 1'b0;
      pa[i] = '0;
      pd[i] = '0;
    end
    model_reset();
    drive_ports();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // A response with nothing outstanding right after reset must be odd.
    m_rval = 1'b1;
    m_rdat = 8'h3C;
    run_cycle();

    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) do_reset();
      new_stimulus();
      drive_ports();
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
